// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle main controller: opcodes, ALUOp codes,
// FSM state encodings and the opcode class used by the decode logic.
package ctrl_pkg;

  localparam int OP_RTYPE = 0;
  localparam int OP_J     = 2;
  localparam int OP_BEQ   = 4;
  localparam int OP_BNE   = 5;
  localparam int OP_ADDI  = 8;
  localparam int OP_SLTIU = 11;
  localparam int OP_ORI   = 13;
  localparam int OP_LUI   = 15;
  localparam int OP_LW    = 35;
  localparam int OP_SW    = 43;

  localparam int ALUOP_RTYPE = 0;
  localparam int ALUOP_BEQ   = 1;
  localparam int ALUOP_BNE   = 2;
  localparam int ALUOP_ADD   = 3;
  localparam int ALUOP_SLTIU = 4;
  localparam int ALUOP_ORI   = 5;
  localparam int ALUOP_LUI   = 6;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_WB_R   = 4'd4,
    S_EXEC_I = 4'd5,
    S_WB_I   = 4'd6,
    S_ADDR   = 4'd7,
    S_MEM_RD = 4'd8,
    S_WB_MEM = 4'd9,
    S_MEM_WR = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12
  } state_e;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LD,
    CLS_ST,
    CLS_BR,
    CLS_J,
    CLS_ILL
  } op_class_e;

endpackage

// File: rtl/multicycle_main_ctrl_if.sv
// Controller-to-datapath bundle: opcode and memory handshake in, ALUOp,
// strobes, mux selects and debug state out.
interface multicycle_main_ctrl_if #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3
);
  logic [OP_W-1:0]    instr_op_i;
  logic               mem_ready_i;
  logic [ALUOP_W-1:0] ALUOp_o;
  logic               alu_src_a_o;
  logic [1:0]         alu_src_b_o;
  logic [1:0]         pc_src_o;
  logic               pc_write_o;
  logic               pc_write_cond_o;
  logic               iord_o;
  logic               mem_read_o;
  logic               mem_write_o;
  logic               ir_write_o;
  logic               reg_dst_o;
  logic               mem_to_reg_o;
  logic               reg_write_o;
  logic               illegal_o;
  logic [3:0]         state_o;

  modport master (
    input  instr_op_i, mem_ready_i,
    output ALUOp_o, alu_src_a_o, alu_src_b_o, pc_src_o, pc_write_o,
           pc_write_cond_o, iord_o, mem_read_o, mem_write_o, ir_write_o,
           reg_dst_o, mem_to_reg_o, reg_write_o, illegal_o, state_o
  );

  modport slave (
    output instr_op_i, mem_ready_i,
    input  ALUOp_o, alu_src_a_o, alu_src_b_o, pc_src_o, pc_write_o,
           pc_write_cond_o, iord_o, mem_read_o, mem_write_o, ir_write_o,
           reg_dst_o, mem_to_reg_o, reg_write_o, illegal_o, state_o
  );
endinterface

// File: rtl/op_class_dec.sv
// Combinational opcode classifier: instruction class, the ALUOp that the
// class-specific execute state needs, and an unknown-opcode flag.
module op_class_dec
  import ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3
) (
  input  logic [OP_W-1:0]    op,
  output op_class_e          op_class,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               illegal
);

  always_comb begin
    op_class = CLS_ILL;
    alu_op   = ALUOP_W'(ALUOP_ADD);
    case (op)
      OP_W'(OP_RTYPE): op_class = CLS_R;
      OP_W'(OP_ADDI):  op_class = CLS_I;
      OP_W'(OP_SLTIU): begin
        op_class = CLS_I;
        alu_op   = ALUOP_W'(ALUOP_SLTIU);
      end
      OP_W'(OP_ORI): begin
        op_class = CLS_I;
        alu_op   = ALUOP_W'(ALUOP_ORI);
      end
      OP_W'(OP_LUI): begin
        op_class = CLS_I;
        alu_op   = ALUOP_W'(ALUOP_LUI);
      end
      OP_W'(OP_LW): op_class = CLS_LD;
      OP_W'(OP_SW): op_class = CLS_ST;
      OP_W'(OP_BEQ): begin
        op_class = CLS_BR;
        alu_op   = ALUOP_W'(ALUOP_BEQ);
      end
      OP_W'(OP_BNE): begin
        op_class = CLS_BR;
        alu_op   = ALUOP_W'(ALUOP_BNE);
      end
      OP_W'(OP_J): op_class = CLS_J;
      default:     op_class = CLS_ILL;
    endcase
  end

  assign illegal = (op_class == CLS_ILL);

endmodule

// File: rtl/multicycle_main_ctrl.sv
// Multicycle main control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, drives
// every datapath strobe and select, and is the only source of ALUOp.
module multicycle_main_ctrl
  import ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  multicycle_main_ctrl_if.master bus
);

  state_e             state_q;
  state_e             state_d;
  op_class_e          op_class;
  logic [ALUOP_W-1:0] cls_alu_op;
  logic               op_illegal;

  op_class_dec #(
    .OP_W    (OP_W),
    .ALUOP_W (ALUOP_W)
  ) u_op_class_dec (
    .op       (bus.instr_op_i),
    .op_class (op_class),
    .alu_op   (cls_alu_op),
    .illegal  (op_illegal)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d             = state_q;
    bus.ALUOp_o         = ALUOP_W'(ALUOP_ADD);
    bus.alu_src_a_o     = 1'b0;
    bus.alu_src_b_o     = 2'd0;
    bus.pc_src_o        = 2'd0;
    bus.pc_write_o      = 1'b0;
    bus.pc_write_cond_o = 1'b0;
    bus.iord_o          = 1'b0;
    bus.mem_read_o      = 1'b0;
    bus.mem_write_o     = 1'b0;
    bus.ir_write_o      = 1'b0;
    bus.reg_dst_o       = 1'b0;
    bus.mem_to_reg_o    = 1'b0;
    bus.reg_write_o     = 1'b0;
    bus.illegal_o       = 1'b0;
    bus.state_o         = state_q;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      // PC+4 is computed alongside the read; IR and PC only load once memory answers
      S_FETCH: begin
        bus.mem_read_o  = 1'b1;
        bus.alu_src_b_o = 2'd1;
        if (bus.mem_ready_i) begin
          bus.ir_write_o = 1'b1;
          bus.pc_write_o = 1'b1;
          state_d        = S_DECODE;
        end
      end

      S_DECODE: begin
        bus.alu_src_b_o = 2'd3;
        case (op_class)
          CLS_R:         state_d = S_EXEC_R;
          CLS_I:         state_d = S_EXEC_I;
          CLS_LD, CLS_ST: state_d = S_ADDR;
          CLS_BR:        state_d = S_BRANCH;
          CLS_J:         state_d = S_JUMP;
          default: begin
            bus.illegal_o = op_illegal;
            state_d       = S_FETCH;
          end
        endcase
      end

      S_EXEC_R: begin
        bus.alu_src_a_o = 1'b1;
        bus.ALUOp_o     = ALUOP_W'(ALUOP_RTYPE);
        state_d         = S_WB_R;
      end

      S_WB_R: begin
        bus.reg_dst_o   = 1'b1;
        bus.reg_write_o = 1'b1;
        state_d         = S_FETCH;
      end

      S_EXEC_I: begin
        bus.alu_src_a_o = 1'b1;
        bus.alu_src_b_o = 2'd2;
        bus.ALUOp_o     = cls_alu_op;
        state_d         = S_WB_I;
      end

      S_WB_I: begin
        bus.reg_write_o = 1'b1;
        state_d         = S_FETCH;
      end

      S_ADDR: begin
        bus.alu_src_a_o = 1'b1;
        bus.alu_src_b_o = 2'd2;
        state_d         = (op_class == CLS_ST) ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        bus.mem_read_o = 1'b1;
        bus.iord_o     = 1'b1;
        if (bus.mem_ready_i) state_d = S_WB_MEM;
      end

      S_WB_MEM: begin
        bus.mem_to_reg_o = 1'b1;
        bus.reg_write_o  = 1'b1;
        state_d          = S_FETCH;
      end

      S_MEM_WR: begin
        bus.mem_write_o = 1'b1;
        bus.iord_o      = 1'b1;
        if (bus.mem_ready_i) state_d = S_FETCH;
      end

      // Target was parked in ALUOut during DECODE; the ALU now compares rs/rt
      S_BRANCH: begin
        bus.alu_src_a_o     = 1'b1;
        bus.pc_src_o        = 2'd1;
        bus.pc_write_cond_o = 1'b1;
        bus.ALUOp_o         = cls_alu_op;
        state_d             = S_FETCH;
      end

      S_JUMP: begin
        bus.pc_src_o   = 2'd2;
        bus.pc_write_o = 1'b1;
        state_d        = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_main_ctrl.sv
// Bench for multicycle_main_ctrl: per-instruction expected cycle sequences
// built from the instruction rules, directed vectors, random programs and reset cases.
module tb_multicycle_main_ctrl;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_i = ~clk_i;

  multicycle_main_ctrl_if #(.OP_W(6), .ALUOP_W(3)) bus ();

  multicycle_main_ctrl #(.OP_W(6), .ALUOP_W(3)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] alu;
    logic       sa;
    logic [1:0] sb;
    logic [1:0] ps;
    logic       pw, pwc, iord, mr, mw, irw, rd, m2r, rw, ill;
  } obs_t;

  typedef struct {
    logic [5:0] op;
    logic       rdy;
    obs_t       exp;
  } step_t;

  typedef struct {
    logic [5:0] op;
    int         fw;
    int         mw;
  } vec_t;

  step_t plan[$];
  vec_t  vecs[12];

  function automatic obs_t sample();
    obs_t o;
    o.st  = bus.state_o;        o.alu = bus.ALUOp_o;
    o.sa  = bus.alu_src_a_o;    o.sb  = bus.alu_src_b_o;
    o.ps  = bus.pc_src_o;       o.pw  = bus.pc_write_o;
    o.pwc = bus.pc_write_cond_o; o.iord = bus.iord_o;
    o.mr  = bus.mem_read_o;     o.mw  = bus.mem_write_o;
    o.irw = bus.ir_write_o;     o.rd  = bus.reg_dst_o;
    o.m2r = bus.mem_to_reg_o;   o.rw  = bus.reg_write_o;
    o.ill = bus.illegal_o;
    return o;
  endfunction

  function automatic obs_t at_state(input int s);
    obs_t o;
    o     = '0;
    o.st  = 4'(s);
    o.alu = 3'd3;
    return o;
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'd0, 6'd2, 6'd4, 6'd5, 6'd8, 6'd11, 6'd13, 6'd15, 6'd35, 6'd43};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [5:0] op, input logic rdy, input obs_t o);
    step_t s;
    s.op = op; s.rdy = rdy; s.exp = o;
    plan.push_back(s);
  endtask

  // Expected cycles of one instruction with fw withheld fetch readies and mw withheld data readies
  task automatic add_instr(input logic [5:0] op, input int fw, input int mw);
    obs_t o;
    for (int i = 0; i < fw; i++) begin
      o = at_state(1); o.mr = 1; o.sb = 2'd1; push(op, 1'b0, o);
    end
    o = at_state(1); o.mr = 1; o.sb = 2'd1; o.irw = 1; o.pw = 1; push(op, 1'b1, o);
    o = at_state(2); o.sb = 2'd3;
    if (!is_legal(op)) begin
      o.ill = 1; push(op, 1'($urandom_range(0, 1)), o);
      return;
    end
    push(op, 1'($urandom_range(0, 1)), o);
    case (op)
      6'd0: begin
        o = at_state(3); o.sa = 1; o.alu = 3'd0; push(op, 1'($urandom_range(0, 1)), o);
        o = at_state(4); o.rd = 1; o.rw = 1;     push(op, 1'($urandom_range(0, 1)), o);
      end
      6'd8, 6'd11, 6'd13, 6'd15: begin
        o = at_state(5); o.sa = 1; o.sb = 2'd2;
        o.alu = (op == 6'd8) ? 3'd3 : (op == 6'd11) ? 3'd4 : (op == 6'd13) ? 3'd5 : 3'd6;
        push(op, 1'($urandom_range(0, 1)), o);
        o = at_state(6); o.rw = 1; push(op, 1'($urandom_range(0, 1)), o);
      end
      6'd35, 6'd43: begin
        o = at_state(7); o.sa = 1; o.sb = 2'd2; push(op, 1'($urandom_range(0, 1)), o);
        for (int i = 0; i <= mw; i++) begin
          o = at_state(op == 6'd35 ? 8 : 10); o.iord = 1;
          if (op == 6'd35) o.mr = 1; else o.mw = 1;
          push(op, (i == mw), o);
        end
        if (op == 6'd35) begin
          o = at_state(9); o.m2r = 1; o.rw = 1; push(op, 1'($urandom_range(0, 1)), o);
        end
      end
      6'd4, 6'd5: begin
        o = at_state(11); o.sa = 1; o.ps = 2'd1; o.pwc = 1;
        o.alu = (op == 6'd4) ? 3'd1 : 3'd2;
        push(op, 1'($urandom_range(0, 1)), o);
      end
      default: begin
        o = at_state(12); o.ps = 2'd2; o.pw = 1; push(op, 1'($urandom_range(0, 1)), o);
      end
    endcase
  endtask

  task automatic run_plan(input string tag);
    step_t s;
    int    n = 0;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      @(posedge clk_i); #1;
      bus.instr_op_i  = s.op;
      bus.mem_ready_i = s.rdy;
      @(negedge clk_i);
      chk($sformatf("%s_cyc%0d_op%0d", tag, n, s.op), 32'(sample()), 32'(s.exp));
      n++;
    end
  endtask

  task automatic step(input logic [5:0] op, input logic rdy);
    @(posedge clk_i); #1;
    bus.instr_op_i  = op;
    bus.mem_ready_i = rdy;
    @(negedge clk_i);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] rop;
    bus.instr_op_i  = '0;
    bus.mem_ready_i = 1'b0;

    vecs[0]  = '{6'd0,  0, 0};
    vecs[1]  = '{6'd13, 0, 0};
    vecs[2]  = '{6'd15, 0, 0};
    vecs[3]  = '{6'd35, 0, 3};
    vecs[4]  = '{6'd5,  0, 0};
    vecs[5]  = '{6'd63, 0, 0};
    vecs[6]  = '{6'd43, 1, 2};
    vecs[7]  = '{6'd4,  2, 0};
    vecs[8]  = '{6'd2,  0, 0};
    vecs[9]  = '{6'd8,  1, 0};
    vecs[10] = '{6'd11, 0, 0};
    vecs[11] = '{6'd35, 0, 0};

    // Reset state
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_idle", 32'(sample()), 32'(at_state(0)));
    @(posedge clk_i); #1 rst_i = 1'b1;
    @(negedge clk_i);
    chk("release_idle", 32'(bus.state_o), 32'd0);

    // lw interrupted by reset while waiting in MEM_RD
    step(6'd35, 1'b1); chk("rst_seq_fetch", 32'(bus.state_o), 32'd1);
    step(6'd35, 1'b1); chk("rst_seq_decode", 32'(bus.state_o), 32'd2);
    step(6'd35, 1'b1); chk("rst_seq_addr", 32'(bus.state_o), 32'd7);
    step(6'd35, 1'b0); chk("rst_seq_memrd", 32'(bus.state_o), 32'd8);
    chk("rst_seq_memrd_read", 32'(bus.mem_read_o), 32'd1);
    #2 rst_i = 1'b0;
    #1;
    chk("rst_mid_state", 32'(bus.state_o), 32'd0);
    chk("rst_mid_mem_read", 32'(bus.mem_read_o), 32'd0);
    chk("rst_mid_reg_write", 32'(bus.reg_write_o), 32'd0);
    @(posedge clk_i); #1 rst_i = 1'b1;
    @(negedge clk_i);
    chk("rst_rel_idle", 32'(bus.state_o), 32'd0);
    step(6'd35, 1'b1);
    chk("rst_rel_fetch", 32'(bus.state_o), 32'd1);
    chk("rst_rel_fetch_read", 32'(bus.mem_read_o), 32'd1);

    // Return to IDLE so every plan starts from a clean instruction boundary
    #1 rst_i = 1'b0;
    @(posedge clk_i); #1 rst_i = 1'b1;
    @(negedge clk_i);
    chk("rst2_idle", 32'(bus.state_o), 32'd0);

    for (int v = 0; v < 12; v++) begin
      add_instr(vecs[v].op, vecs[v].fw, vecs[v].mw);
      run_plan($sformatf("vec%0d", v));
    end

    for (int r = 0; r < 60; r++) begin
      if ($urandom_range(0, 7) == 0) begin
        do rop = 6'($urandom_range(0, 63)); while (is_legal(rop));
      end else begin
        case ($urandom_range(0, 9))
          0: rop = 6'd0;   1: rop = 6'd2;   2: rop = 6'd4;  3: rop = 6'd5;
          4: rop = 6'd8;   5: rop = 6'd11;  6: rop = 6'd13; 7: rop = 6'd15;
          8: rop = 6'd35;  default: rop = 6'd43;
        endcase
      end
      add_instr(rop, $urandom_range(0, 2), $urandom_range(0, 3));
    end
    run_plan("rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
